// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic (poly 0x11D), RS code constants and Forney FSM state encoding.
package gf_pkg;

  localparam int unsigned SYMB_WIDTH = 8;
  localparam int unsigned GF_ORDER   = (1 << SYMB_WIDTH) - 1;
  localparam logic [SYMB_WIDTH:0] GF_POLY = 9'h11D;
  localparam int unsigned N_LEN      = 255;
  localparam int unsigned T_LEN      = 8;
  localparam int unsigned ROOTS_NUM  = 16;
  localparam int          FIRST_ROOT = 1;

  typedef logic [SYMB_WIDTH-1:0] symb_t;

  typedef enum logic [2:0] {StIdle, StOmega, StEval, StDiv, StOut, StFin} state_t;

  function automatic symb_t gf_xtime(symb_t a);
    return a[SYMB_WIDTH-1] ? ((a << 1) ^ GF_POLY[SYMB_WIDTH-1:0]) : (a << 1);
  endfunction

  function automatic symb_t gf_mult(symb_t a, symb_t b);
    symb_t p;
    symb_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Square-and-multiply; exponent assumed already reduced below GF_ORDER.
  function automatic symb_t gf_pow(symb_t x, symb_t e);
    symb_t r;
    symb_t b;
    r = symb_t'(1);
    b = x;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (e[i]) r = gf_mult(r, b);
      b = gf_mult(b, b);
    end
    return r;
  endfunction

  function automatic symb_t gf_alpha_pow(symb_t e);
    return gf_pow(symb_t'(2), e);
  endfunction

  function automatic symb_t gf_inv(symb_t x);
    return gf_pow(x, symb_t'(GF_ORDER - 1));
  endfunction

  function automatic symb_t gf_div(symb_t a, symb_t b);
    return gf_mult(a, gf_inv(b));
  endfunction

  // Exponent (1 - fcr) mod GF_ORDER used to scale Omega by Xi^(1-fcr).
  function automatic symb_t gf_fcr_exp(int fcr);
    int e;
    e = (1 - fcr) % int'(GF_ORDER);
    if (e < 0) e = e + int'(GF_ORDER);
    return symb_t'(e);
  endfunction

endpackage

// File: rtl/rs_horner_step.sv
// One Horner step on two lanes (Omega, Lambda') sharing the Xi^-1 multiplier operand.
module rs_horner_step
  import gf_pkg::*;
#(
  parameter int unsigned SYMB_WIDTH = gf_pkg::SYMB_WIDTH
) (
  input  logic [SYMB_WIDTH-1:0] acc_om,
  input  logic [SYMB_WIDTH-1:0] acc_d,
  input  logic [SYMB_WIDTH-1:0] xi_inv,
  input  logic [SYMB_WIDTH-1:0] om_coef,
  input  logic [SYMB_WIDTH-1:0] d_coef,
  output logic [SYMB_WIDTH-1:0] acc_om_nxt,
  output logic [SYMB_WIDTH-1:0] acc_d_nxt
);

  always_comb begin
    acc_om_nxt = gf_mult(acc_om, xi_inv) ^ om_coef;
    acc_d_nxt  = gf_mult(acc_d, xi_inv) ^ d_coef;
  end

endmodule

// File: rtl/rs_forney_seq.sv
// Sequential Forney engine: serial Omega = S*Lambda mod x^ROOTS_NUM, shared Horner evaluation,
// one (position, magnitude) beat per error. RS_FORNEY_DEG_CHECK_EN adds err_uncorrectable.
module rs_forney_seq
  import gf_pkg::*;
#(
  parameter int unsigned T_LEN      = gf_pkg::T_LEN,
  parameter int unsigned ROOTS_NUM  = gf_pkg::ROOTS_NUM,
  parameter int unsigned N_LEN      = gf_pkg::N_LEN,
  parameter int          FIRST_ROOT = gf_pkg::FIRST_ROOT,
  parameter int unsigned SYMB_WIDTH = gf_pkg::SYMB_WIDTH
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 s_vld,
  output logic                                 s_rdy,
  input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] s_syndrome,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]       s_err_loc,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]     s_err_pos,
  input  logic [T_LEN-1:0]                     s_err_pos_vld,
  output logic                                 m_vld,
  input  logic                                 m_rdy,
  output logic [SYMB_WIDTH-1:0]                m_pos,
  output logic [SYMB_WIDTH-1:0]                m_mag,
  output logic                                 m_last,
  output logic                                 m_zero_deriv,
  output logic                                 done
`ifdef RS_FORNEY_DEG_CHECK_EN
  ,
  output logic                                 err_uncorrectable
`endif
);

  localparam int unsigned CW = (ROOTS_NUM > 1) ? $clog2(ROOTS_NUM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROOTS_NUM - 1);
  localparam symb_t POS_MAX   = symb_t'(N_LEN - 1);
  localparam symb_t SCALE_EXP = gf_fcr_exp(FIRST_ROOT);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] syn_q, omega_q;
  logic [T_LEN:0][SYMB_WIDTH-1:0] lam_q;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_q;
  logic [T_LEN-1:0] mask_q, slot_q;
  symb_t xi_q, xi_inv_q, cur_pos_q, acc_om_q, acc_d_q;

  logic accept, hshake, sel_load;
  logic [T_LEN-1:0] rem_mask, sel_mask, sel_slot;
  symb_t sel_pos, sel_xi, omega_k, om_coef, d_coef, acc_om_nxt, acc_d_nxt, num, mag;

  always_comb begin
    s_rdy  = (state_q == StIdle);
    accept = s_vld & s_rdy;
    hshake = (state_q == StOut) & m_rdy;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (s_vld) state_d = (s_err_pos_vld == '0) ? StFin : StOmega;
      StOmega: if (cnt_q == CNT_LAST) state_d = StEval;
      StEval:  if (cnt_q == '0) state_d = StDiv;
      StDiv:   state_d = StOut;
      StOut:   if (m_rdy) state_d = (rem_mask == '0) ? StFin : StEval;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next slot is the lowest remaining mask bit; in OUT the current slot is already excluded.
  always_comb begin
    rem_mask = mask_q & ~slot_q;
    sel_mask = (state_q == StOut) ? rem_mask : mask_q;
    sel_slot = sel_mask & (~sel_mask + T_LEN'(1));
    sel_pos  = '0;
    for (int i = 0; i < int'(T_LEN); i++) begin
      if (sel_slot[i]) sel_pos = sel_pos | pos_q[i];
    end
    sel_xi   = gf_alpha_pow(POS_MAX - sel_pos);
    sel_load = ((state_q == StOmega) && (cnt_q == CNT_LAST)) || hshake;
  end

  always_comb begin
    omega_k = '0;
    for (int j = 0; j <= int'(T_LEN); j++) begin
      if (j <= int'(cnt_q)) omega_k = omega_k ^ gf_mult(lam_q[j], syn_q[int'(cnt_q) - j]);
    end
    om_coef = omega_q[cnt_q];
    // Formal derivative in characteristic 2 keeps only odd-power Lambda terms.
    d_coef = '0;
    if (!cnt_q[0] && (int'(cnt_q) < int'(T_LEN))) d_coef = lam_q[int'(cnt_q) + 1];
  end

  rs_horner_step #(
    .SYMB_WIDTH(SYMB_WIDTH)
  ) u_horner (
    .acc_om    (acc_om_q),
    .acc_d     (acc_d_q),
    .xi_inv    (xi_inv_q),
    .om_coef   (om_coef),
    .d_coef    (d_coef),
    .acc_om_nxt(acc_om_nxt),
    .acc_d_nxt (acc_d_nxt)
  );

  always_comb begin
    num = (FIRST_ROOT == 1) ? acc_om_q : gf_mult(gf_pow(xi_q, SCALE_EXP), acc_om_q);
    mag = (acc_d_q == '0) ? '0 : gf_div(num, acc_d_q);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q        <= '0;
      syn_q        <= '0;
      omega_q      <= '0;
      lam_q        <= '0;
      pos_q        <= '0;
      mask_q       <= '0;
      slot_q       <= '0;
      xi_q         <= '0;
      xi_inv_q     <= '0;
      cur_pos_q    <= '0;
      acc_om_q     <= '0;
      acc_d_q      <= '0;
      m_vld        <= 1'b0;
      m_pos        <= '0;
      m_mag        <= '0;
      m_last       <= 1'b0;
      m_zero_deriv <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state_q == StFin);
      if (accept) begin
        syn_q  <= s_syndrome;
        lam_q  <= s_err_loc;
        pos_q  <= s_err_pos;
        mask_q <= s_err_pos_vld;
        slot_q <= '0;
        cnt_q  <= '0;
      end
      if (state_q == StOmega) begin
        omega_q[cnt_q] <= omega_k;
        if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
      end
      if (sel_load) begin
        slot_q    <= sel_slot;
        cur_pos_q <= sel_pos;
        xi_q      <= sel_xi;
        xi_inv_q  <= gf_inv(sel_xi);
        acc_om_q  <= '0;
        acc_d_q   <= '0;
        cnt_q     <= CNT_LAST;
      end
      if (state_q == StEval) begin
        acc_om_q <= acc_om_nxt;
        acc_d_q  <= acc_d_nxt;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == StDiv) begin
        m_vld        <= 1'b1;
        m_pos        <= cur_pos_q;
        m_mag        <= mag;
        m_zero_deriv <= (acc_d_q == '0);
        m_last       <= (rem_mask == '0);
      end
      if (hshake) begin
        m_vld  <= 1'b0;
        mask_q <= rem_mask;
      end
    end
  end

`ifdef RS_FORNEY_DEG_CHECK_EN
  logic deg_bad_q, zd_seen_q;
  int unsigned pop_cnt, lam_deg;

  always_comb begin
    pop_cnt = 0;
    lam_deg = 0;
    for (int i = 0; i < int'(T_LEN); i++) pop_cnt = pop_cnt + 32'(s_err_pos_vld[i]);
    for (int i = 0; i <= int'(T_LEN); i++) begin
      if (s_err_loc[i] != '0) lam_deg = i;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      deg_bad_q         <= 1'b0;
      zd_seen_q         <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      err_uncorrectable <= (state_q == StFin) & (deg_bad_q | zd_seen_q);
      if (accept) begin
        deg_bad_q <= (pop_cnt != lam_deg);
        zd_seen_q <= 1'b0;
      end else if ((state_q == StDiv) && (acc_d_q == '0)) begin
        zd_seen_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rs_forney_seq.sv
// Directed bench for rs_forney_seq: syndromes and Lambda built from injected errors.
module tb_rs_forney_seq;
  import gf_pkg::*;

  localparam int TL = T_LEN;
  localparam int RN = ROOTS_NUM;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic s_vld = 1'b0;
  logic s_rdy;
  logic [RN-1:0][7:0] s_syndrome = '0;
  logic [TL:0][7:0] s_err_loc = '0;
  logic [TL-1:0][7:0] s_err_pos = '0;
  logic [TL-1:0] s_err_pos_vld = '0;
  logic m_vld;
  logic m_rdy = 1'b0;
  logic [7:0] m_pos, m_mag;
  logic m_last, m_zero_deriv, done;
`ifdef RS_FORNEY_DEG_CHECK_EN
  logic err_uncorrectable;
`endif

  rs_forney_seq dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_vld        (s_vld),
    .s_rdy        (s_rdy),
    .s_syndrome   (s_syndrome),
    .s_err_loc    (s_err_loc),
    .s_err_pos    (s_err_pos),
    .s_err_pos_vld(s_err_pos_vld),
    .m_vld        (m_vld),
    .m_rdy        (m_rdy),
    .m_pos        (m_pos),
    .m_mag        (m_mag),
    .m_last       (m_last),
    .m_zero_deriv (m_zero_deriv),
    .done         (done)
`ifdef RS_FORNEY_DEG_CHECK_EN
    ,
    .err_uncorrectable(err_uncorrectable)
`endif
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int saw_done = 0;

  logic [7:0] gexp [0:509];
  int glog [0:255];
  logic [7:0] tpos [0:TL-1];
  logic [7:0] tmag [0:TL-1];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Lambda = prod(1 + Xi x) and S_j = sum e_i Xi^(FIRST_ROOT+j) over err_mask slots.
  task automatic load(input logic [TL-1:0] err_mask, input logic [TL-1:0] drv_mask);
    logic [7:0] lam [0:TL];
    logic [7:0] sj;
    int c;
    for (int k = 0; k <= TL; k++) lam[k] = 8'h00;
    lam[0] = 8'h01;
    for (int s = 0; s < TL; s++) begin
      if (err_mask[s]) begin
        c = int'(N_LEN) - 1 - int'(tpos[s]);
        for (int k = TL; k >= 1; k--) lam[k] = lam[k] ^ gmul(gexp[c], lam[k-1]);
      end
    end
    for (int j = 0; j < RN; j++) begin
      sj = 8'h00;
      for (int s = 0; s < TL; s++) begin
        if (err_mask[s]) begin
          c = int'(N_LEN) - 1 - int'(tpos[s]);
          sj = sj ^ gmul(tmag[s], gexp[(c * (FIRST_ROOT + j)) % 255]);
        end
      end
      s_syndrome[j] = sj;
    end
    for (int k = 0; k <= TL; k++) s_err_loc[k] = lam[k];
    for (int s = 0; s < TL; s++) s_err_pos[s] = tpos[s];
    s_err_pos_vld = drv_mask;
    saw_done = 0;
  endtask

  task automatic accept(input string tag);
    check({tag, " s_rdy"}, s_rdy, 1);
    s_vld = 1'b1;
    tick();
    s_vld = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int lat, input logic [7:0] pos,
                             input logic [7:0] mag, input logic last, input int stall);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (done) saw_done++;
    end while (!m_vld && cyc < 100);
    check({tag, " latency"}, cyc, lat);
    check({tag, " vld"}, m_vld, 1);
    check({tag, " pos"}, m_pos, pos);
    check({tag, " mag"}, m_mag, mag);
    check({tag, " last"}, m_last, last);
    check({tag, " zero_deriv"}, m_zero_deriv, 0);
    check({tag, " s_rdy busy"}, s_rdy, 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " stall vld"}, m_vld, 1);
      check({tag, " stall pos"}, m_pos, pos);
      check({tag, " stall mag"}, m_mag, mag);
      check({tag, " stall last"}, m_last, last);
    end
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic unc);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 100);
    check({tag, " done latency"}, cyc, 1);
    check({tag, " no vld at done"}, m_vld, 0);
`ifdef RS_FORNEY_DEG_CHECK_EN
    check({tag, " err_uncorrectable"}, err_uncorrectable, unc);
`else
    if (unc) check({tag, " unc expectation"}, 1, 0);
`endif
    tick();
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 510; i++) begin
      gexp[i] = x[7:0];
      if (i < 255) glog[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    for (int s = 0; s < TL; s++) begin
      tpos[s] = 8'h00;
      tmag[s] = 8'h00;
    end

    // Reset state
    repeat (3) tick();
    check("reset s_rdy", s_rdy, 1);
    check("reset m_vld", m_vld, 0);
    check("reset done", done, 0);
    check("reset m_mag", m_mag, 0);
    check("reset m_last", m_last, 0);
    areset = 1'b0;
    tick();

    // Empty mask: done one cycle after accept, no beat
    load('0, '0);
    accept("empty");
    wait_done("empty", 1'b0);

    // Single error, pos 10, magnitude 0x5A
    tpos[0] = 8'd10;
    tmag[0] = 8'h5A;
    load(8'h01, 8'h01);
    accept("single");
    expect_beat("single", 33, 8'd10, 8'h5A, 1'b1, 0);
    check("single no early done", saw_done, 0);
    wait_done("single", 1'b0);

    // Eight errors, full mask
    tpos = '{8'd3, 8'd17, 8'd40, 8'd77, 8'd100, 8'd150, 8'd201, 8'd254};
    tmag = '{8'h11, 8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80, 8'h6E, 8'hD2};
    load(8'hFF, 8'hFF);
    accept("eight");
    for (int s = 0; s < TL; s++) begin
      expect_beat($sformatf("eight b%0d", s), (s == 0) ? 33 : 17, tpos[s], tmag[s],
                  (s == TL - 1), 0);
    end
    wait_done("eight", 1'b0);

    // Sparse mask 0x24 with 5-cycle stalls; unmasked slots carry junk positions
    tpos = '{8'h77, 8'h77, 8'd33, 8'h77, 8'h77, 8'd120, 8'h77, 8'h77};
    tmag = '{8'h00, 8'h00, 8'h44, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00};
    load(8'h24, 8'h24);
    accept("sparse");
    expect_beat("sparse b0", 33, 8'd33, 8'h44, 1'b0, 5);
    expect_beat("sparse b1", 17, 8'd120, 8'hC3, 1'b1, 5);
    wait_done("sparse", 1'b0);

    // Reset mid-EVAL, then a fresh codeword
    tpos = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tmag = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(8'h01, 8'h01);
    accept("midrst");
    repeat (20) tick();
    areset = 1'b1;
    #1;
    check("midrst m_vld", m_vld, 0);
    check("midrst done", done, 0);
    check("midrst s_rdy", s_rdy, 1);
    check("midrst m_pos", m_pos, 0);
    tick();
    areset = 1'b0;
    tick();
    tpos[0] = 8'd200;
    tmag[0] = 8'h33;
    load(8'h01, 8'h01);
    accept("after rst");
    expect_beat("after rst", 33, 8'd200, 8'h33, 1'b1, 0);
    check("after rst no stale done", saw_done, 0);
    wait_done("after rst", 1'b0);

`ifdef RS_FORNEY_DEG_CHECK_EN
    // Lambda of degree 3 but only two slots flagged
    tpos = '{8'd5, 8'd60, 8'd130, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    tmag = '{8'h21, 8'h42, 8'h84, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(8'h07, 8'h03);
    accept("degchk");
    expect_beat("degchk b0", 33, 8'd5, 8'h21, 1'b0, 0);
    expect_beat("degchk b1", 17, 8'd60, 8'h42, 1'b1, 0);
    wait_done("degchk", 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_forney_seq.md
Name: rs_forney_seq

Overview:
Sequential, parametrised Forney error-magnitude engine for the RS decoder.
- Takes syndrome S(x), error-locator polynomial Λ(x) from Berlekamp-Massey, and the error-position list from the Chien search.
- Computes Ω(x) = S(x)·Λ(x) mod x^ROOTS_NUM serially, then evaluates Ω and Λ' at each Xi^-1 with a shared Horner datapath.
- Streams one (position, magnitude) beat per error over a valid/ready interface. This replaces the fully combinational magnitude path with a low-area, multi-cycle engine that supports backpressure.

Parameters:
- T_LEN, gf_pkg::T_LEN: maximum correctable errors (number of position slots).
- ROOTS_NUM, gf_pkg::ROOTS_NUM: syndrome count; must satisfy ROOTS_NUM >= T_LEN+1.
- N_LEN, gf_pkg::N_LEN: codeword length in symbols.
- FIRST_ROOT, gf_pkg::FIRST_ROOT: first consecutive root (fcr) of the generator.
- SYMB_WIDTH, gf_pkg::SYMB_WIDTH: symbol width; the field is fixed by gf_pkg.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_vld  in  1  input bundle valid.
- s_rdy  out  1  high only in IDLE.
- s_syndrome  in  ROOTS_NUM x SYMB_WIDTH  S0..S(ROOTS_NUM-1).
- s_err_loc  in  (T_LEN+1) x SYMB_WIDTH  Λ coefficients; index 0 = constant term (=1).
- s_err_pos  in  T_LEN x SYMB_WIDTH  codeword symbol index of each error.
- s_err_pos_vld  in  T_LEN  per-slot valid mask; any bit pattern is legal.
- m_vld  out  1  magnitude beat valid.
- m_rdy  in  1  downstream ready.
- m_pos  out  SYMB_WIDTH  error position of this beat.
- m_mag  out  SYMB_WIDTH  error magnitude.
- m_last  out  1  last beat of the codeword.
- m_zero_deriv  out  1  Λ'(Xi^-1)=0 for this beat; m_mag is forced to 0.
- done  out  1  one-cycle pulse when the codeword has finished.

Behaviour:
- Reset: all outputs 0, except s_rdy=1 once the FSM is in IDLE. State returns to IDLE and all working registers clear. A reset mid-operation discards the codeword and emits no beat or done.
- Accept: on s_vld & s_rdy, register all inputs.
  - Mask zero: go to FIN.
  - Mask nonzero: go to OMEGA.
- OMEGA, ROOTS_NUM cycles, counter k=0..ROOTS_NUM-1:
  - ω_k = XOR over j=0..min(k,T_LEN) of gf_mult(Λ_j, S_(k-j)).
  - Uses T_LEN+1 parallel multipliers and writes one coefficient per cycle.
- Slot select: the next slot is the lowest set bit remaining in the mask. Compute:
  - c = N_LEN-1-pos
  - Xi = gf_alpha_pow(c)
  - Xi_inv = gf_inv(Xi)
  - These are registered, one cycle, overlapped with the last OMEGA/OUT cycle.
- EVAL, ROOTS_NUM cycles, index i from ROOTS_NUM-1 down to 0:
  - accΩ = accΩ·Xi_inv ^ ω_i.
  - accD = accD·Xi_inv ^ d_i, where d_i = Λ_(i+1) if i even and i+1 <= T_LEN, else 0 (formal derivative, characteristic 2).
- DIV, 1 cycle:
  - accD == 0: m_mag=0, m_zero_deriv=1.
  - Otherwise: m_mag = gf_div(gf_mult(Xi^(1-FIRST_ROOT), accΩ), accD). When FIRST_ROOT==1 the multiplier is bypassed.
  - m_vld rises and the FSM enters OUT.
- OUT: m_* outputs are held stable while m_vld & !m_rdy. On the handshake:
  - clear the slot's mask bit;
  - if more slots remain, go to EVAL; otherwise go to FIN.
- m_last=1 on the beat whose slot is the last set bit.
- FIN: done=1 for one cycle, then IDLE.
- Latency:
  - first m_vld = 2·ROOTS_NUM+1 cycles after the accept edge;
  - each subsequent m_vld = ROOTS_NUM+1 cycles after the previous handshake;
  - done = 1 cycle after the last handshake, or 1 cycle after accept for an empty mask.
- Simultaneous s_vld during a busy period is ignored (s_rdy=0); nothing is lost because the upstream side holds.

Optional Feature:
- Macro RS_FORNEY_DEG_CHECK_EN.
- Enabled:
  - Adds output err_uncorrectable (1 bit, reset 0), valid with done.
  - Set when popcount(s_err_pos_vld) != deg Λ, where deg Λ is the highest nonzero coefficient index.
  - Also set when any beat of the codeword had m_zero_deriv.
  - When the mismatch is detected at accept, all beats are still emitted.
- Disabled: the port and the check logic are absent.

Decomposition:
- gf_pkg:
  - gf_mult, gf_div, gf_inv, gf_alpha_pow (α^e);
  - pow helper for Xi^(1-FIRST_ROOT);
  - typedef symb_t;
  - an enum for FSM states IDLE/OMEGA/EVAL/DIV/OUT/FIN.
- One sub-module, rs_horner_step: two-lane (accΩ, accD) single Horner step with a shared Xi_inv multiplier operand.

Test Plan:
- No errors (mask=0): done pulses 1 cycle after accept; m_vld never rises.
- Single error, magnitude 0x5A at position 10, RS(255,239) with golden-model S and Λ: one beat with m_pos=10, m_mag=0x5A, m_last=1. First m_vld arrives 33 cycles after accept.
- 8 errors in slots with mask 0xFF and random magnitudes: 8 beats in ascending slot order with golden magnitudes, m_last only on the 8th.
- Sparse mask 0x24 (2 errors) with m_rdy held low 5 cycles per beat: outputs stay stable while stalled; exactly 2 beats; next beat arrives ROOTS_NUM+1=17 cycles after each handshake.
- Reset asserted mid-EVAL, then a new codeword: outputs go to 0 immediately; the new codeword produces correct beats with no stale beat or done.
- Degree check (macro on): Λ of degree 3 with mask 0x03 → err_uncorrectable=1 with done, 2 beats emitted.
